// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, 8 data bits LSB first, parity, stop bit.
// Each bit is held for CLKS_PER_BIT clocks; all outputs are registered.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_out,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_idx, w_idx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_tx_out, w_tx_out_nx;
  logic          r_busy, w_busy_nx;
  logic          r_done, w_done_nx;
  logic          w_last;
  logic          w_parity;

  assign w_last   = (r_cnt == LAST);
  // Parity comes from the captured byte so mid-frame tx_data changes cannot leak in.
  assign w_parity = (^r_shift) ^ PARITY_ODD;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx_out <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_idx    <= w_idx_nx;
      r_shift  <= w_shift_nx;
      r_tx_out <= w_tx_out_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt + CW'(1);
    w_idx_nx    = r_idx;
    w_shift_nx  = r_shift;
    w_tx_out_nx = r_tx_out;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nx    = '0;
        w_tx_out_nx = 1'b1;
        w_busy_nx   = 1'b0;
        if (i_tx_start) begin
          w_shift_nx  = i_tx_data;
          w_state_nx  = START;
          w_tx_out_nx = 1'b0;
          w_busy_nx   = 1'b1;
        end
      end
      START: begin
        if (w_last) begin
          w_state_nx  = DATA;
          w_cnt_nx    = '0;
          w_idx_nx    = 3'd0;
          w_tx_out_nx = r_shift[0];
        end
      end
      DATA: begin
        if (w_last) begin
          w_cnt_nx = '0;
          if (r_idx == 3'd7) begin
            w_state_nx  = PARITY;
            w_tx_out_nx = w_parity;
          end else begin
            w_idx_nx    = r_idx + 3'd1;
            w_tx_out_nx = r_shift[r_idx + 3'd1];
          end
        end
      end
      PARITY: begin
        if (w_last) begin
          w_state_nx  = STOP;
          w_cnt_nx    = '0;
          w_tx_out_nx = 1'b1;
        end
      end
      STOP: begin
        if (w_last) begin
          w_state_nx  = IDLE;
          w_cnt_nx    = '0;
          w_tx_out_nx = 1'b1;
          w_busy_nx   = 1'b0;
          w_done_nx   = 1'b1;
        end
      end
      default: begin
        w_state_nx  = IDLE;
        w_cnt_nx    = '0;
        w_tx_out_nx = 1'b1;
        w_busy_nx   = 1'b0;
      end
    endcase
  end

  assign o_tx_out  = r_tx_out;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: one even-parity and one odd-parity instance,
// every cycle of each frame compared against hand-computed line values.
module tb_uart_tx_frame;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_e, start_o;
  logic [7:0] data_e, data_o;
  logic       out_e, busy_e, done_e;
  logic       out_o, busy_o, done_o;
  logic       sel;
  logic       mon_out, mon_busy, mon_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut_e (
    .i_clock(clk), .i_reset(rst), .i_tx_start(start_e), .i_tx_data(data_e),
    .o_tx_out(out_e), .o_tx_busy(busy_e), .o_tx_done(done_e));

  uart_tx_frame #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_o (
    .i_clock(clk), .i_reset(rst), .i_tx_start(start_o), .i_tx_data(data_o),
    .o_tx_out(out_o), .o_tx_busy(busy_o), .o_tx_done(done_o));

  assign mon_out  = sel ? out_o  : out_e;
  assign mon_busy = sel ? busy_o : busy_e;
  assign mon_done = sel ? done_o : done_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] d);
    if (sel) begin start_o = s; data_o = d; end
    else     begin start_e = s; data_e = d; end
  endtask

  // Leaves the bench at the negedge of the first start-bit cycle.
  task automatic kick(input logic [7:0] d);
    @(negedge clk);
    drive(1'b1, d);
    @(negedge clk);
    drive(1'b0, d);
  endtask

  // Walks 11*C cycles from the first start-bit cycle; optionally injects a
  // start request with other data at cycle inj. Ends at the tx_done cycle.
  task automatic frame_check(input string tag, input logic [7:0] d, input logic par,
                             input int inj, input logic [7:0] inj_d);
    logic [10:0] bits;
    int glitches, busy_low;
    bits = {1'b1, par, d, 1'b0};
    glitches = 0;
    busy_low = 0;
    for (int cyc = 0; cyc < 11 * C; cyc++) begin
      if (cyc == inj) drive(1'b1, inj_d);
      else if (cyc == inj + 1) drive(1'b0, d);
      if (mon_out !== bits[cyc / C]) glitches++;
      if (mon_busy !== 1'b1) busy_low++;
      if (cyc % C == C / 2)
        check($sformatf("%s bit%0d", tag, cyc / C), 32'(mon_out), 32'(bits[cyc / C]));
      if (cyc % C == C - 1 && mon_done !== 1'b0) busy_low++;
      @(negedge clk);
    end
    check({tag, " line_errs"}, 32'(glitches), 32'd0);
    check({tag, " busy_errs"}, 32'(busy_low), 32'd0);
    check({tag, " done"}, {29'd0, mon_done, mon_busy, mon_out}, 32'b101);
  endtask

  initial begin
    int pulses;
    sel = 1'b0;
    start_e = 1'b0; start_o = 1'b0; data_e = 8'h00; data_o = 8'h00;
    rst = 1'b1;
    #1;
    check("reset_async", {29'd0, out_e, busy_e, done_e}, 32'b100);
    repeat (3) @(negedge clk);
    check("reset_hold", {29'd0, out_e, busy_e, done_e}, 32'b100);
    rst = 1'b0;
    @(negedge clk);
    check("idle", {29'd0, out_e, busy_e, done_e}, 32'b100);

    kick(8'hA5);
    frame_check("A5", 8'hA5, 1'b0, -10, 8'h00);
    @(negedge clk);
    check("A5 done_one_cycle", 32'(done_e), 32'd0);

    kick(8'hFF);
    frame_check("FF_even", 8'hFF, 1'b0, -10, 8'h00);
    kick(8'h07);
    frame_check("07_even", 8'h07, 1'b1, -10, 8'h00);

    sel = 1'b1;
    kick(8'h00);
    frame_check("00_odd", 8'h00, 1'b1, -10, 8'h00);
    kick(8'h01);
    frame_check("01_odd", 8'h01, 1'b0, -10, 8'h00);
    sel = 1'b0;

    // A request mid-frame must be dropped, not queued.
    kick(8'h81);
    frame_check("81_busy", 8'h81, 1'b0, 49, 8'h3C);
    pulses = 0;
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      if (done_e !== 1'b0 || busy_e !== 1'b0 || out_e !== 1'b1) pulses++;
    end
    check("81 no_second_frame", 32'(pulses), 32'd0);

    // Back-to-back with start held high; data changes mid-frame are ignored.
    @(negedge clk);
    drive(1'b1, 8'h55);
    @(negedge clk);
    drive(1'b1, 8'hAA);
    frame_check("55_b2b", 8'h55, 1'b0, -10, 8'h00);
    @(negedge clk);
    drive(1'b0, 8'hAA);
    frame_check("AA_b2b", 8'hAA, 1'b0, -10, 8'h00);
    @(negedge clk);
    check("AA idle_after", {29'd0, out_e, busy_e, done_e}, 32'b100);

    // Reset during data bit 3 (frame slot 4) takes effect without a clock edge.
    kick(8'h33);
    repeat (4 * C + C / 2) @(negedge clk);
    check("pre_reset busy", 32'(busy_e), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_reset", {29'd0, out_e, busy_e, done_e}, 32'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < C; i++) begin
      @(negedge clk);
      if (done_e !== 1'b0 || out_e !== 1'b1) pulses++;
    end
    check("post_reset quiet", 32'(pulses), 32'd0);

    // Byte set the receive side must accept.
    kick(8'h00);
    frame_check("lb_00", 8'h00, 1'b0, -10, 8'h00);
    kick(8'hFF);
    frame_check("lb_FF", 8'hFF, 1'b0, -10, 8'h00);
    kick(8'h5A);
    frame_check("lb_5A", 8'h5A, 1'b0, -10, 8'h00);
    kick(8'hC3);
    frame_check("lb_C3", 8'hC3, 1'b0, -10, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
